// File: rtl/ifm_window_fetch_if.sv
// BRAM read port plus the PE-side valid/ready window stream of ifm_window_fetch.
interface ifm_window_fetch_if #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20
);
   logic [ADDR_WIDTH-1:0] rd_addr;
   logic                  rd_en;
   logic [DATA_WIDTH-1:0] bram_data;
   logic [DATA_WIDTH-1:0] out_data;
   logic                  out_valid;
   logic                  out_ready;
   logic                  out_last;

   modport master (
      output rd_addr, rd_en, out_data, out_valid, out_last,
      input  bram_data, out_ready
   );
   modport slave (
      input  rd_addr, rd_en, out_data, out_valid, out_last,
      output bram_data, out_ready
   );
endinterface

// File: rtl/ifm_window_fetch.sv
// Walks a 1x1/3x3, stride 1/2, same-padded window over a pixel-major IFM tile,
// issuing BRAM reads and streaming window words (zeros for padding) through a 2-entry FIFO.
module ifm_window_fetch #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 20
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [7:0] cfg_h,
   input  logic [7:0] cfg_w,
   input  logic [9:0] cfg_cw,
   input  logic       cfg_k3,
   input  logic       cfg_s2,
   output logic       busy,
   output logic       done,
   ifm_window_fetch_if.master bus
);
   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
   state_t state_q, state_d;

   logic [7:0] h_q, w_q, oh, ow;
   logic [9:0] cw_q;
   logic       k3_q, s2_q;
   logic [7:0] oy_q, ox_q;
   logic [1:0] ky_q, kx_q, kmax;
   logic [9:0] c_q;
   logic       c_end, kx_end, ky_end, ox_end, oy_end, win_last, pass_last;
   logic [9:0] oy_s, ox_s, iy, ix;
   logic       in_bounds;
   logic [ADDR_WIDTH-1:0] pix, word;

   logic [1:0][DATA_WIDTH:0] mem_q, mem_d;
   logic [1:0] occ_q, occ_d, wp;
   logic       infl_q, infl_last_q;
   logic [2:0] pend;
   logic       pop, issue, issue_rd, issue_pad, done_d;

   assign oh   = cfg_s2_round(h_q);
   assign ow   = cfg_s2_round(w_q);
   assign kmax = k3_q ? 2'd2 : 2'd0;

   function automatic logic [7:0] cfg_s2_round(input logic [7:0] v);
      return s2_q ? 8'((9'(v) + 9'd1) >> 1) : v;
   endfunction

   assign c_end     = (c_q == cw_q - 10'd1);
   assign kx_end    = (kx_q == kmax);
   assign ky_end    = (ky_q == kmax);
   assign ox_end    = (ox_q == ow - 8'd1);
   assign oy_end    = (oy_q == oh - 8'd1);
   assign win_last  = c_end & kx_end & ky_end;
   assign pass_last = win_last & ox_end & oy_end;

   // Two's-complement 10-bit coordinates; bit 9 set means the window hangs off the top/left edge.
   assign oy_s = s2_q ? {1'b0, oy_q, 1'b0} : {2'b00, oy_q};
   assign ox_s = s2_q ? {1'b0, ox_q, 1'b0} : {2'b00, ox_q};
   assign iy   = oy_s - {9'd0, k3_q} + {8'd0, ky_q};
   assign ix   = ox_s - {9'd0, k3_q} + {8'd0, kx_q};
   assign in_bounds = !iy[9] && (iy[8:0] < {1'b0, h_q}) && !ix[9] && (ix[8:0] < {1'b0, w_q});

   assign pix  = ADDR_WIDTH'(iy[7:0]) * ADDR_WIDTH'(w_q) + ADDR_WIDTH'(ix[7:0]);
   assign word = pix * ADDR_WIDTH'(cw_q) + ADDR_WIDTH'(c_q);

   // Credit includes this cycle's pop so the stream sustains one word per cycle.
   assign pop       = (occ_q != 2'd0) && bus.out_ready;
   assign pend      = {1'b0, occ_q} + {2'b00, infl_q} - {2'b00, pop};
   assign issue     = (state_q == RUN) && (pend < 3'd2);
   assign issue_rd  = issue & in_bounds;
   assign issue_pad = issue & ~in_bounds;

   assign bus.rd_en     = issue_rd;
   assign bus.rd_addr   = issue_rd ? (word << 2) : '0;
   assign bus.out_valid = (occ_q != 2'd0);
   assign bus.out_data  = mem_q[0][DATA_WIDTH-1:0];
   assign bus.out_last  = mem_q[0][DATA_WIDTH] & bus.out_valid;
   assign busy          = (state_q != IDLE);

   // Returning read data is older than a pad issued this cycle, so it is written first.
   always_comb begin
      mem_d = mem_q;
      wp    = occ_q - {1'b0, pop};
      if (pop) mem_d[0] = mem_q[1];
      if (infl_q) begin
         mem_d[wp[0]] = {infl_last_q, bus.bram_data};
         wp = wp + 2'd1;
      end
      if (issue_pad) begin
         mem_d[wp[0]] = {win_last, {DATA_WIDTH{1'b0}}};
         wp = wp + 2'd1;
      end
      occ_d = wp;
   end

   always_comb begin
      state_d = state_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE:    if (start) state_d = RUN;
         RUN:     if (issue && pass_last) state_d = DRAIN;
         DRAIN:   if (!infl_q && occ_q == 2'd1 && pop) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         done        <= 1'b0;
         mem_q       <= '0;
         occ_q       <= 2'd0;
         infl_q      <= 1'b0;
         infl_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         done        <= done_d;
         mem_q       <= mem_d;
         occ_q       <= occ_d;
         infl_q      <= issue_rd;
         infl_last_q <= win_last;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         h_q  <= 8'd0;  w_q  <= 8'd0;  cw_q <= 10'd0;
         k3_q <= 1'b0;  s2_q <= 1'b0;
         oy_q <= 8'd0;  ox_q <= 8'd0;  ky_q <= 2'd0;  kx_q <= 2'd0;  c_q <= 10'd0;
      end else if (state_q == IDLE && start) begin
         h_q  <= cfg_h;  w_q  <= cfg_w;  cw_q <= cfg_cw;
         k3_q <= cfg_k3; s2_q <= cfg_s2;
         oy_q <= 8'd0;  ox_q <= 8'd0;  ky_q <= 2'd0;  kx_q <= 2'd0;  c_q <= 10'd0;
      end else if (issue) begin
         if (!c_end) c_q <= c_q + 10'd1;
         else begin
            c_q <= 10'd0;
            if (!kx_end) kx_q <= kx_q + 2'd1;
            else begin
               kx_q <= 2'd0;
               if (!ky_end) ky_q <= ky_q + 2'd1;
               else begin
                  ky_q <= 2'd0;
                  if (!ox_end) ox_q <= ox_q + 8'd1;
                  else begin
                     ox_q <= 8'd0;
                     oy_q <= oy_q + 8'd1;
                  end
               end
            end
         end
      end
   end
endmodule
